// File: rtl/nad_pkg.sv
// Shared types and constants for the game scheduler.
package nad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam int unsigned SCREEN_W   = 640;
    localparam int unsigned NUM_SLOTS  = 2;
    localparam logic [9:0]  SPAWN_X    = 10'd639;
    localparam logic [6:0]  GAP_INIT   = 7'd64;
    localparam logic [6:0]  GAP_MIN    = 7'd40;
    localparam logic [2:0]  SPEED_INIT = 3'd2;
    localparam logic [2:0]  SPEED_MAX  = 3'd6;
    localparam logic [13:0] SCORE_MAX  = 14'd16383;
    localparam logic [7:0]  LFSR_SEED  = 8'hA5;
    // Right-shift Galois mask for x^8+x^6+x^5+x^4+1
    localparam logic [7:0]  LFSR_TAPS  = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {1'b0, cur[7:1]} ^ (cur[0] ? LFSR_TAPS : 8'h00);
    endfunction

endpackage

// File: rtl/nad_lfsr.sv
// Free-running 8-bit Galois LFSR; advances every clock, seeded on reset.
module nad_lfsr
    import nad_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] value
);

    logic [7:0] r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_lfsr <= LFSR_SEED;
        else        r_lfsr <= lfsr_next(r_lfsr);
    end

    assign value = r_lfsr;

endmodule

// File: rtl/game_scheduler.sv
// Endless-runner obstacle scheduler: per-frame scroll, spawn, score and game FSM.
// Optional speed ramp built only when SPEED_RAMP_EN is defined.
module game_scheduler
    import nad_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        btn_jump,
    input  logic        collision,
    output logic [1:0]  state,
    output logic [1:0]  obs_valid,
    output logic [9:0]  obs0_x,
    output logic [9:0]  obs1_x,
    output logic [1:0]  obs_kind,
    output logic [2:0]  speed,
    output logic [13:0] score
);

    state_t                 r_state, w_state_nx;
    logic [NUM_SLOTS-1:0]   r_valid, w_valid_nx;
    logic [9:0]             r_x [NUM_SLOTS];
    logic [9:0]             w_x_nx [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]   r_kind, w_kind_nx;
    logic [2:0]             r_speed, w_speed_nx;
    logic [13:0]            r_score, w_score_nx, w_score_inc;
    logic [6:0]             r_gap, w_gap_nx;
    logic                   r_released, w_released_nx;
    logic [NUM_SLOTS-1:0]   w_free;
    logic                   w_placed;
    logic [7:0]             w_lfsr;
    logic                   w_unused_lfsr;

    nad_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .value (w_lfsr)
    );

    assign w_unused_lfsr = ^w_lfsr[7:6];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_valid    <= '0;
            r_x        <= '{default: '0};
            r_kind     <= '0;
            r_speed    <= SPEED_INIT;
            r_score    <= '0;
            r_gap      <= GAP_INIT;
            r_released <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_valid    <= w_valid_nx;
            r_x        <= w_x_nx;
            r_kind     <= w_kind_nx;
            r_speed    <= w_speed_nx;
            r_score    <= w_score_nx;
            r_gap      <= w_gap_nx;
            r_released <= w_released_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_valid_nx    = r_valid;
        w_x_nx        = r_x;
        w_kind_nx     = r_kind;
        w_speed_nx    = r_speed;
        w_score_nx    = r_score;
        w_gap_nx      = r_gap;
        w_released_nx = r_released;
        w_placed      = 1'b0;
        // Free mask taken before clears so an expiring slot is not reused this frame
        w_free        = ~r_valid;
        w_score_inc   = (r_score == SCORE_MAX) ? r_score : r_score + 14'd1;

        if (frame_tick) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (btn_jump) begin
                        w_state_nx = ST_RUN;
                        w_valid_nx = '0;
                        w_score_nx = '0;
                        w_speed_nx = SPEED_INIT;
                        w_gap_nx   = GAP_INIT;
                    end
                end
                ST_RUN: begin
                    if (collision) begin
                        w_state_nx    = ST_OVER;
                        w_released_nx = 1'b0;
                    end else begin
                        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                            if (r_valid[i]) begin
                                if (r_x[i] < {7'd0, r_speed}) w_valid_nx[i] = 1'b0;
                                else                          w_x_nx[i] = r_x[i] - {7'd0, r_speed};
                            end
                        end
                        w_score_nx = w_score_inc;
`ifdef SPEED_RAMP_EN
                        if ((r_score != SCORE_MAX) && (w_score_inc[8:0] == 9'd0) &&
                            (r_speed < SPEED_MAX))
                            w_speed_nx = r_speed + 3'd1;
`endif
                        if (r_gap != 7'd0) begin
                            w_gap_nx = r_gap - 7'd1;
                        end else begin
                            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                                if (w_free[i] && !w_placed) begin
                                    w_placed      = 1'b1;
                                    w_valid_nx[i] = 1'b1;
                                    w_x_nx[i]     = SPAWN_X;
                                    w_kind_nx[i]  = w_lfsr[0];
                                    w_gap_nx      = GAP_MIN + {2'b00, w_lfsr[5:1]};
                                end
                            end
                        end
                    end
                end
                ST_OVER: begin
                    // Restart needs a release tick before a press tick
                    if (!btn_jump) begin
                        w_released_nx = 1'b1;
                    end else if (r_released) begin
                        w_state_nx    = ST_IDLE;
                        w_released_nx = 1'b0;
                    end
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    assign state     = r_state;
    assign obs_valid = r_valid;
    assign obs0_x    = r_x[0];
    assign obs1_x    = r_x[1];
    assign obs_kind  = r_kind;
    assign speed     = r_speed;
    assign score     = r_score;

endmodule

// File: tb/tb_game_scheduler.sv
// Directed self-checking bench for game_scheduler with a small behavioural reference.
`timescale 1ns/1ps
module tb_game_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        btn_jump = 1'b0;
    logic        collision = 1'b0;
    logic [1:0]  state;
    logic [1:0]  obs_valid;
    logic [9:0]  obs0_x, obs1_x;
    logic [1:0]  obs_kind;
    logic [2:0]  speed;
    logic [13:0] score;

    int total = 0;
    int bad   = 0;

    game_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .btn_jump   (btn_jump),
        .collision  (collision),
        .state      (state),
        .obs_valid  (obs_valid),
        .obs0_x     (obs0_x),
        .obs1_x     (obs1_x),
        .obs_kind   (obs_kind),
        .speed      (speed),
        .score      (score)
    );

    always #5 clk = ~clk;

    // Reference game state
    logic [7:0]  m_lfsr;
    logic [1:0]  m_state, m_valid, m_kind;
    logic [9:0]  m_x0, m_x1;
    logic [2:0]  m_speed;
    logic [13:0] m_score;
    logic [6:0]  m_gap;
    logic        m_rel;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else if (m_lfsr[0]) m_lfsr <= (m_lfsr >> 1) ^ 8'hB8;
        else m_lfsr <= m_lfsr >> 1;
    end

    task automatic model_reset();
        m_state = 2'd0; m_valid = 2'b00; m_kind = 2'b00; m_x0 = 10'd0; m_x1 = 10'd0;
        m_speed = 3'd2; m_score = 14'd0; m_gap = 7'd64; m_rel = 1'b0;
    endtask

    task automatic model_step(input logic b, input logic c);
        logic [1:0] free;
        if (m_state == 2'd0) begin
            if (b) begin
                m_state = 2'd1; m_valid = 2'b00; m_score = 14'd0; m_speed = 3'd2; m_gap = 7'd64;
            end
        end else if (m_state == 2'd1) begin
            if (c) begin
                m_state = 2'd2; m_rel = 1'b0;
            end else begin
                free = ~m_valid;
                if (m_valid[0]) begin
                    if (m_x0 < m_speed) m_valid[0] = 1'b0; else m_x0 = m_x0 - m_speed;
                end
                if (m_valid[1]) begin
                    if (m_x1 < m_speed) m_valid[1] = 1'b0; else m_x1 = m_x1 - m_speed;
                end
                if (m_score != 14'd16383) begin
                    m_score = m_score + 14'd1;
`ifdef SPEED_RAMP_EN
                    if ((m_score % 512) == 0 && m_speed < 3'd6) m_speed = m_speed + 3'd1;
`endif
                end
                if (m_gap > 0) m_gap = m_gap - 7'd1;
                else if (free[0]) begin
                    m_valid[0] = 1'b1; m_x0 = 10'd639; m_kind[0] = m_lfsr[0]; m_gap = 7'd40 + m_lfsr[5:1];
                end else if (free[1]) begin
                    m_valid[1] = 1'b1; m_x1 = 10'd639; m_kind[1] = m_lfsr[0]; m_gap = 7'd40 + m_lfsr[5:1];
                end
            end
        end else begin
            if (!b) m_rel = 1'b1;
            else if (m_rel) begin m_state = 2'd0; m_rel = 1'b0; end
        end
    endtask

    function automatic logic [42:0] dut_vec();
        return {state, obs_valid, obs0_x, obs1_x, obs_kind, speed, score};
    endfunction

    function automatic logic [42:0] mod_vec();
        return {m_state, m_valid, m_x0, m_x1, m_kind, m_speed, m_score};
    endfunction

    task automatic tick(input logic b, input logic c);
        frame_tick = 1'b1; btn_jump = b; collision = c;
        model_step(b, c);
        @(posedge clk); #1;
        frame_tick = 1'b0; collision = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        total++; if (state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", state); end
        total++; if (obs_valid !== 2'b00) begin bad++; $display("FAIL rst_valid got=%b want=00", obs_valid); end
        total++; if (obs0_x !== 10'd0 || obs1_x !== 10'd0) begin bad++; $display("FAIL rst_x got=%0d/%0d want=0/0", obs0_x, obs1_x); end
        total++; if (obs_kind !== 2'b00) begin bad++; $display("FAIL rst_kind got=%b want=00", obs_kind); end
        total++; if (speed !== 3'd2) begin bad++; $display("FAIL rst_speed got=%0d want=2", speed); end
        total++; if (score !== 14'd0) begin bad++; $display("FAIL rst_score got=%0d want=0", score); end
    endtask

    task automatic test_idle();
        btn_jump = 1'b1;
        idle(5);
        total++; if (state !== 2'd0) begin bad++; $display("FAIL idle_no_tick got=%0d want=0", state); end
        tick(1'b0, 1'b0);
        total++; if (state !== 2'd0) begin bad++; $display("FAIL idle_tick_nobtn got=%0d want=0", state); end
    endtask

    task automatic test_start();
        tick(1'b1, 1'b0);
        total++; if (state !== 2'd1) begin bad++; $display("FAIL start_state got=%0d want=1", state); end
        total++; if (score !== 14'd0 || speed !== 3'd2 || obs_valid !== 2'b00)
            begin bad++; $display("FAIL start_vals got score=%0d speed=%0d valid=%b want 0/2/00", score, speed, obs_valid); end
        for (int i = 0; i < 64; i++) tick(1'b0, 1'b0);
        total++; if (obs_valid !== 2'b00 || score !== 14'd64)
            begin bad++; $display("FAIL gap_count got valid=%b score=%0d want 00/64", obs_valid, score); end
        tick(1'b0, 1'b0);
        total++; if (obs_valid[0] !== 1'b1 || obs0_x !== 10'd639 || score !== 14'd65)
            begin bad++; $display("FAIL first_spawn got valid=%b x0=%0d score=%0d want 1/639/65", obs_valid, obs0_x, score); end
        total++; if (obs_kind[0] !== m_kind[0]) begin bad++; $display("FAIL spawn_kind got=%b want=%b", obs_kind[0], m_kind[0]); end
    endtask

    task automatic test_scroll_expiry();
        logic hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            if (m_valid[0] && m_x0 == 10'd1) begin
                hit = 1'b1;
                total++; if (m_valid !== 2'b11 || m_gap !== 7'd0)
                    begin bad++; $display("FAIL full_setup got valid=%b gap=%0d want 11/0", m_valid, m_gap); end
                tick(1'b0, 1'b0);
                total++; if (obs_valid[0] !== 1'b0) begin bad++; $display("FAIL expiry_clear got=%b want=0", obs_valid[0]); end
                tick(1'b0, 1'b0);
                total++; if (obs_valid[0] !== 1'b1 || obs0_x !== 10'd639)
                    begin bad++; $display("FAIL respawn got valid=%b x0=%0d want 1/639", obs_valid[0], obs0_x); end
            end else begin
                tick(1'b0, 1'b0);
                total++; if (dut_vec() !== mod_vec()) begin bad++; $display("FAIL scroll_step got=%h want=%h", dut_vec(), mod_vec()); end
            end
        end
        if (!hit) begin total++; bad++; $display("FAIL expiry_timeout got=none want=x0==1"); end
    endtask

    task automatic test_collision();
        logic [13:0] sc;
        logic [9:0]  x0, x1;
        logic [1:0]  v;
        logic        ok = 1'b0;
        for (int i = 0; i < 120 && !ok; i++) begin
            if (m_state == 2'd1 && m_gap == 7'd0) ok = 1'b1;
            else tick(1'b0, 1'b0);
        end
        if (!ok) begin total++; bad++; $display("FAIL coll_setup_timeout got=gap%0d want=gap0", m_gap); end
        sc = m_score; x0 = m_x0; x1 = m_x1; v = m_valid;
        tick(1'b0, 1'b1);
        total++; if (state !== 2'd2) begin bad++; $display("FAIL coll_state got=%0d want=2", state); end
        total++; if (score !== sc || obs_valid !== v || obs0_x !== x0 || obs1_x !== x1)
            begin bad++; $display("FAIL coll_frozen got s=%0d v=%b x=%0d/%0d want s=%0d v=%b x=%0d/%0d", score, obs_valid, obs0_x, obs1_x, sc, v, x0, x1); end
        tick(1'b1, 1'b0);
        total++; if (state !== 2'd2) begin bad++; $display("FAIL press_only got=%0d want=2", state); end
        tick(1'b0, 1'b1);
        total++; if (state !== 2'd2 || score !== sc) begin bad++; $display("FAIL release_tick got st=%0d s=%0d want 2/%0d", state, score, sc); end
        idle(3);
        tick(1'b1, 1'b0);
        total++; if (state !== 2'd0 || score !== sc) begin bad++; $display("FAIL over_to_idle got st=%0d s=%0d want 0/%0d", state, score, sc); end
    endtask

    task automatic test_back_to_back();
        tick(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0);
        total++; if (score !== 14'd20 || state !== 2'd1 || obs_valid !== 2'b00)
            begin bad++; $display("FAIL b2b got s=%0d st=%0d v=%b want 20/1/00", score, state, obs_valid); end
        total++; if (dut_vec() !== mod_vec()) begin bad++; $display("FAIL b2b_model got=%h want=%h", dut_vec(), mod_vec()); end
    endtask

    task automatic test_reset_mid_run();
        #3 rst_n = 1'b0;
        #1;
        total++; if (state !== 2'd0 || obs_valid !== 2'b00 || score !== 14'd0 || speed !== 3'd2 ||
                     obs0_x !== 10'd0 || obs1_x !== 10'd0 || obs_kind !== 2'b00)
            begin bad++; $display("FAIL async_reset got=%h want=state0/score0/speed2", dut_vec()); end
        model_reset();
        #3 rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_long_run();
        logic [2:0] sp_a, sp_b;
`ifdef SPEED_RAMP_EN
        sp_a = 3'd3; sp_b = 3'd6;
`else
        sp_a = 3'd2; sp_b = 3'd2;
`endif
        tick(1'b1, 1'b0);
        for (int i = 1; i <= 16400; i++) begin
            tick(1'b0, 1'b0);
            if (i % 64 == 0) begin
                total++; if (dut_vec() !== mod_vec()) begin bad++; $display("FAIL long_step%0d got=%h want=%h", i, dut_vec(), mod_vec()); end
            end
            if (i == 511) begin
                total++; if (speed !== 3'd2) begin bad++; $display("FAIL ramp_511 got=%0d want=2", speed); end
            end
            if (i == 512) begin
                total++; if (speed !== sp_a) begin bad++; $display("FAIL ramp_512 got=%0d want=%0d", speed, sp_a); end
            end
            if (i == 2560) begin
                total++; if (speed !== sp_b) begin bad++; $display("FAIL ramp_2560 got=%0d want=%0d", speed, sp_b); end
            end
            if (i == 16383) begin
                total++; if (score !== 14'd16383) begin bad++; $display("FAIL sat_reach got=%0d want=16383", score); end
            end
        end
        total++; if (score !== 14'd16383 || speed !== sp_b)
            begin bad++; $display("FAIL sat_hold got s=%0d sp=%0d want 16383/%0d", score, speed, sp_b); end
    endtask

    initial begin
        #22 rst_n = 1'b1;
        idle(1);
        test_reset();
        test_idle();
        test_start();
        test_scroll_expiry();
        test_collision();
        test_back_to_back();
        test_reset_mid_run();
        test_long_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
